// File: rtl/pspin_hpu_cmd_id_tracker.sv
// HPU command-ID allocator and completion tracker for one cluster.
// Each core owns NUM_HPU_CMDS slots; a slot is busy from grant until its matching completion.
module pspin_hpu_cmd_id_tracker #(
   parameter int unsigned NUM_CORES    = 8,
   parameter int unsigned NUM_HPU_CMDS = 4,
   parameter int unsigned NUM_CLUSTERS = 4,
   localparam int unsigned CL_W  = $clog2(NUM_CLUSTERS),
   localparam int unsigned CO_W  = $clog2(NUM_CORES),
   localparam int unsigned ID_W  = $clog2(NUM_HPU_CMDS),
   localparam int unsigned OC_W  = $clog2(NUM_HPU_CMDS + 1),
   localparam int unsigned RID_W = CL_W + CO_W + ID_W
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [CL_W-1:0]                   cluster_id_i,
   input  logic [NUM_CORES-1:0]              alloc_valid_i,
   output logic [NUM_CORES-1:0]              alloc_ready_o,
   output logic [NUM_CORES*ID_W-1:0]         alloc_id_o,
   input  logic                              resp_valid_i,
   output logic                              resp_ready_o,
   input  logic [RID_W-1:0]                  resp_cmd_id_i,
   output logic [NUM_CORES*NUM_HPU_CMDS-1:0] busy_o,
   output logic [NUM_CORES*OC_W-1:0]         occup_o,
   input  logic                              flush_i,
   output logic                              flush_done_o,
   output logic                              err_o,
   output logic [15:0]                       err_cnt_o
);

   logic [NUM_CORES-1:0][NUM_HPU_CMDS-1:0] busy_q, busy_d, set_mask, clr_mask;
   logic [NUM_CORES-1:0][ID_W-1:0]         free_id;
   logic [NUM_CORES-1:0][OC_W-1:0]         occup_q, occup_d;
   logic [NUM_CORES-1:0]                   any_free, grant, clr_any;
   logic [CL_W-1:0]                        resp_cl;
   logic [CO_W-1:0]                        resp_co;
   logic [ID_W-1:0]                        resp_lid;
   logic                                   slot_busy, resp_hit;
   logic                                   err_q, flush_done_q;
   logic [15:0]                            err_cnt_q;

   assign resp_cl  = resp_cmd_id_i[ID_W+CO_W +: CL_W];
   assign resp_co  = resp_cmd_id_i[ID_W +: CO_W];
   assign resp_lid = resp_cmd_id_i[ID_W-1:0];

   // Lowest free slot per core; scanning downward lets the lowest index win.
   always_comb begin
      for (int c = 0; c < int'(NUM_CORES); c++) begin
         free_id[c]  = '0;
         any_free[c] = 1'b0;
         for (int s = int'(NUM_HPU_CMDS) - 1; s >= 0; s--) begin
            if (!busy_q[c][s]) begin
               free_id[c]  = ID_W'(s);
               any_free[c] = 1'b1;
            end
         end
      end
   end

   assign alloc_ready_o = any_free & {NUM_CORES{~flush_i}};
   assign grant         = alloc_valid_i & alloc_ready_o;

   // Core indices beyond NUM_CORES never match, so they fall out as invalid.
   always_comb begin
      slot_busy = 1'b0;
      for (int c = 0; c < int'(NUM_CORES); c++) begin
         if (resp_co == CO_W'(c) && busy_q[c][resp_lid]) slot_busy = 1'b1;
      end
   end

   assign resp_hit = resp_valid_i && (resp_cl == cluster_id_i) && slot_busy;

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      for (int c = 0; c < int'(NUM_CORES); c++) begin
         for (int s = 0; s < int'(NUM_HPU_CMDS); s++) begin
            set_mask[c][s] = grant[c] && (free_id[c] == ID_W'(s));
            clr_mask[c][s] = resp_hit && (resp_co == CO_W'(c)) && (resp_lid == ID_W'(s));
         end
      end
   end

   // Granted slots are free and cleared slots are busy, so the masks never overlap.
   always_comb begin
      busy_d = (busy_q | set_mask) & ~clr_mask;
      for (int c = 0; c < int'(NUM_CORES); c++) begin
         clr_any[c] = |clr_mask[c];
         occup_d[c] = occup_q[c] + OC_W'(grant[c]) - OC_W'(clr_any[c]);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         busy_q       <= '0;
         occup_q      <= '0;
         err_q        <= 1'b0;
         err_cnt_q    <= '0;
         flush_done_q <= flush_i;
      end else begin
         busy_q       <= busy_d;
         occup_q      <= occup_d;
         err_q        <= resp_valid_i && !resp_hit;
         flush_done_q <= flush_i && (busy_q == '0);
         if (resp_valid_i && !resp_hit && err_cnt_q != 16'hFFFF) begin
            err_cnt_q <= err_cnt_q + 16'd1;
         end
      end
   end

   assign alloc_id_o   = free_id;
   assign busy_o       = busy_q;
   assign occup_o      = occup_q;
   assign resp_ready_o = 1'b1;
   assign err_o        = err_q;
   assign err_cnt_o    = err_cnt_q;
   assign flush_done_o = flush_done_q;

endmodule

// File: tb/tb_pspin_hpu_cmd_id_tracker.sv
// Self-checking bench: directed scenarios plus random traffic against a slot-set reference model.
module tb_pspin_hpu_cmd_id_tracker;
   localparam int unsigned NC = 8, NS = 4, NCL = 4;
   localparam int unsigned CL_W = 2, CO_W = 3, ID_W = 2, OC_W = 3, RID_W = 7;

   bit clk = 1'b0;
   logic rst, resp_valid, resp_ready, flush, flush_done, err;
   logic [CL_W-1:0]    cluster_id;
   logic [NC-1:0]      alloc_valid, alloc_ready;
   logic [NC*ID_W-1:0] alloc_id;
   logic [RID_W-1:0]   resp_cmd_id;
   logic [NC*NS-1:0]   busy;
   logic [NC*OC_W-1:0] occup;
   logic [15:0]        err_cnt;

   pspin_hpu_cmd_id_tracker #(.NUM_CORES(NC), .NUM_HPU_CMDS(NS), .NUM_CLUSTERS(NCL)) dut (
      .clk_i(clk), .rst_i(rst), .cluster_id_i(cluster_id),
      .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready), .alloc_id_o(alloc_id),
      .resp_valid_i(resp_valid), .resp_ready_o(resp_ready), .resp_cmd_id_i(resp_cmd_id),
      .busy_o(busy), .occup_o(occup), .flush_i(flush), .flush_done_o(flush_done),
      .err_o(err), .err_cnt_o(err_cnt));

   always #5 clk = ~clk;

   // Reference model: the set of in-flight IDs per core plus error bookkeeping.
   bit mbusy[NC][NS];
   bit merr, mflush_done;
   int merr_cnt;
   int n_checks = 0, n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int lowest_free(input int c);
      for (int s = 0; s < int'(NS); s++) if (!mbusy[c][s]) return s;
      return -1;
   endfunction

   function automatic int count_busy(input int c);
      int n = 0;
      for (int s = 0; s < int'(NS); s++) n += int'(mbusy[c][s]);
      return n;
   endfunction

   function automatic logic [RID_W-1:0] mk_id(input int cl, input int co, input int id);
      return {2'(cl), 3'(co), 2'(id)};
   endfunction

   // One clock: drive at negedge, compare against the model, advance model, idle inputs after the edge.
   task automatic cycle(input bit r, input logic [NC-1:0] av, input bit rv,
                        input logic [RID_W-1:0] rid, input bit fl);
      int lf[NC];
      bit all_idle, hit;
      int rcl, rco, rlid;
      @(negedge clk);
      rst = r; alloc_valid = av; resp_valid = rv; resp_cmd_id = rid; flush = fl;
      #1;
      for (int c = 0; c < int'(NC); c++) lf[c] = lowest_free(c);
      if (!r) begin
         for (int c = 0; c < int'(NC); c++) begin
            check($sformatf("ready[%0d]", c), 32'(alloc_ready[c]), 32'(lf[c] >= 0 && !fl));
            check($sformatf("id[%0d]", c), 32'(alloc_id[c*ID_W +: ID_W]), 32'(lf[c] >= 0 ? lf[c] : 0));
            check($sformatf("occup[%0d]", c), 32'(occup[c*OC_W +: OC_W]), 32'(count_busy(c)));
            for (int s = 0; s < int'(NS); s++)
               check($sformatf("busy[%0d][%0d]", c, s), 32'(busy[c*NS+s]), 32'(mbusy[c][s]));
         end
         check("err", 32'(err), 32'(merr));
         check("err_cnt", 32'(err_cnt), 32'(merr_cnt));
         check("flush_done", 32'(flush_done), 32'(mflush_done));
         check("resp_ready", 32'(resp_ready), 32'd1);
      end
      if (r) begin
         foreach (mbusy[c, s]) mbusy[c][s] = 1'b0;
         merr = 1'b0; merr_cnt = 0; mflush_done = fl;
      end else begin
         all_idle = 1'b1;
         foreach (mbusy[c, s]) if (mbusy[c][s]) all_idle = 1'b0;
         rcl = int'(rid[6:5]); rco = int'(rid[4:2]); rlid = int'(rid[1:0]);
         hit = rv && rcl == int'(cluster_id) && rco < int'(NC) && mbusy[rco][rlid];
         mflush_done = fl && all_idle;
         merr = rv && !hit;
         if (merr && merr_cnt < 65535) merr_cnt++;
         for (int c = 0; c < int'(NC); c++) if (av[c] && !fl && lf[c] >= 0) mbusy[c][lf[c]] = 1'b1;
         if (hit) mbusy[rco][rlid] = 1'b0;
      end
      @(posedge clk);
      #1;
      rst = 1'b0; alloc_valid = '0; resp_valid = 1'b0; resp_cmd_id = '0;
   endtask

   logic [NC*NS-1:0] saved_busy;
   logic [NC-1:0]    av_r;
   bit               rv_r, fl_r;
   logic [RID_W-1:0] rid_r;
   int               pick[$];
   int               phase;

   initial begin
      rst = 1'b1; cluster_id = 2'd2; alloc_valid = '0; resp_valid = 1'b0;
      resp_cmd_id = '0; flush = 1'b0;

      // Reset state
      cycle(1, '0, 0, '0, 0);
      cycle(1, '0, 0, '0, 0);
      check("t1_ready", 32'(alloc_ready), 32'hFF);
      check("t1_id", 32'(alloc_id), 32'h0);
      check("t1_occup", 32'(occup), 32'h0);
      check("t1_err_cnt", 32'(err_cnt), 32'h0);
      check("t1_flush_done", 32'(flush_done), 32'h0);

      // Fill core 3 one slot per cycle
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t2_id%0d", i), 32'(alloc_id[3*ID_W +: ID_W]), 32'(i));
         cycle(0, 8'h08, 0, '0, 0);
      end
      check("t2_ready3", 32'(alloc_ready[3]), 32'd0);
      check("t2_occup3", 32'(occup[3*OC_W +: OC_W]), 32'd4);
      check("t2_other_ready", 32'(alloc_ready & 8'hF7), 32'hF7);

      // Free slot 2 of full core 3, then reallocate it
      cycle(0, '0, 1, mk_id(2, 3, 2), 0);
      check("t3_busy3", 32'(busy[3*NS +: NS]), 32'hB);
      check("t3_id3", 32'(alloc_id[3*ID_W +: ID_W]), 32'd2);
      check("t3_occup3", 32'(occup[3*OC_W +: OC_W]), 32'd3);
      cycle(0, 8'h08, 0, '0, 0);
      check("t3_busy3_refill", 32'(busy[3*NS +: NS]), 32'hF);

      // Full core 0: same-cycle alloc stalls while slot 1 frees
      for (int i = 0; i < 4; i++) cycle(0, 8'h01, 0, '0, 0);
      cycle(0, 8'h01, 1, mk_id(2, 0, 1), 0);
      check("t4_ready0", 32'(alloc_ready[0]), 32'd1);
      check("t4_id0", 32'(alloc_id[1:0]), 32'd1);
      check("t4_occup0_mid", 32'(occup[2:0]), 32'd3);
      cycle(0, 8'h01, 0, '0, 0);
      check("t4_occup0", 32'(occup[2:0]), 32'd4);

      // Invalid completions
      saved_busy = busy;
      cycle(0, '0, 1, mk_id(1, 0, 0), 0);
      check("t5_err_a", 32'(err), 32'd1);
      check("t5_cnt_a", 32'(err_cnt), 32'd1);
      cycle(0, '0, 1, mk_id(2, 5, 3), 0);
      check("t5_err_b", 32'(err), 32'd1);
      check("t5_cnt_b", 32'(err_cnt), 32'd2);
      cycle(0, '0, 0, '0, 0);
      check("t5_err_low", 32'(err), 32'd0);
      check("t5_busy", 32'(busy), 32'(saved_busy));

      // Flush with three in flight on core 1
      cycle(1, '0, 0, '0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 8'h02, 0, '0, 0);
      cycle(0, '0, 0, '0, 1);
      check("t6_ready_blocked", 32'(alloc_ready), 32'h0);
      cycle(0, 8'hFF, 1, mk_id(2, 1, 0), 1);
      cycle(0, '0, 1, mk_id(2, 1, 1), 1);
      cycle(0, '0, 1, mk_id(2, 1, 2), 1);
      check("t6_done_early", 32'(flush_done), 32'd0);
      cycle(0, '0, 0, '0, 1);
      check("t6_done", 32'(flush_done), 32'd1);
      cycle(0, '0, 0, '0, 0);
      check("t6_ready_back", 32'(alloc_ready), 32'hFF);
      check("t6_done_drop", 32'(flush_done), 32'd0);

      // Random traffic alternating fill-heavy and drain-heavy phases
      fl_r = 1'b0;
      phase = 0;
      for (int n = 0; n < 3000; n++) begin
         if (n % 150 == 0) phase = 1 - phase;
         if (phase == 0) av_r = 8'($urandom);
         else av_r = ($urandom_range(3) == 0) ? 8'(1 << $urandom_range(7)) : 8'h0;
         pick.delete();
         foreach (mbusy[c, s]) if (mbusy[c][s]) pick.push_back(c * int'(NS) + s);
         rv_r = ($urandom_range(99) < 70);
         if ($urandom_range(99) < 75 && pick.size() > 0) begin
            int e;
            e = pick[$urandom_range(pick.size() - 1)];
            rid_r = mk_id(2, e / int'(NS), e % int'(NS));
         end else begin
            rid_r = RID_W'($urandom);
         end
         if ($urandom_range(99) < 3) fl_r = ~fl_r;
         cycle(($urandom_range(999) < 2), av_r, rv_r, rid_r, fl_r);
      end
      cycle(0, '0, 0, '0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
